// File: rtl/outdata_ser_pkg.sv
// Shared definitions for the outbound packet serializer: default widths,
// FSM state encoding, packet counter width and the beat parity helper.
package outdata_ser_pkg;

    localparam int PKT_WIDTH_DEF  = 128;
    localparam int BEAT_WIDTH_DEF = 32;
    localparam int PKT_CNT_W      = 16;

    // Widest beat the parity helper accepts; narrower beats are zero-extended.
    localparam int PAR_MAX_W      = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Even parity of a beat: XOR reduction, so an odd number of ones gives 1.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage : outdata_ser_pkg

// File: rtl/outdata_serializer.sv
// outdata_serializer: pops whole packets from the outbound double buffer and
// sends them as BEAT_WIDTH beats, least-significant beat first, on a
// valid/ready bus with a last-beat marker. A new packet is popped in the same
// cycle as the last beat of the previous one, so packets run back-to-back.
//
// Optional build macro:
//   OUTDATA_SER_PARITY_EN - adds out_par, the even parity of out_data.
//
// PKT_WIDTH must be a multiple of BEAT_WIDTH and hold at least two beats.
module outdata_serializer
    import outdata_ser_pkg::*;
#(
    parameter int PKT_WIDTH  = PKT_WIDTH_DEF,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_vld,
    input  logic [PKT_WIDTH-1:0]  buf_din,
    output logic                  buf_rd,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
`ifdef OUTDATA_SER_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    localparam int NUM_BEATS = PKT_WIDTH / BEAT_WIDTH;
    localparam int IDX_W     = (NUM_BEATS > 2) ? $clog2(NUM_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    ser_state_t           state_q,    state_d;
    logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
    // Packet shift register: the current beat always sits in the low slice.
    logic [PKT_WIDTH-1:0] shift_q,    shift_d;

    logic xfer;
    logic last_xfer;

    // Output view of the registered state; nothing here depends on out_rdy.
    always_comb begin
        out_vld  = (state_q == SEND);
        busy     = (state_q == SEND);
        out_last = (state_q == SEND) && (beat_idx_q == LAST_IDX);
        out_data = shift_q[BEAT_WIDTH-1:0];
    end

    assign xfer      = out_vld & out_rdy;
    assign last_xfer = xfer & out_last;

    // Pop strobe: in IDLE, or on the last-beat transfer for back-to-back
    // packets. Reset masks it so a packet is never popped while being reset.
    assign buf_rd = buf_vld & ~rst & ((state_q == IDLE) | last_xfer);

`ifdef OUTDATA_SER_PARITY_EN
    // Parity follows the registered beat, so it is stable under stall.
    assign out_par = even_parity({{(PAR_MAX_W - BEAT_WIDTH){1'b0}}, out_data});
`endif

    // Next-state logic: capture on pop, advance on transfer, hold on stall.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        shift_d    = shift_q;

        unique case (state_q)
            IDLE: begin
                if (buf_rd) begin
                    state_d    = SEND;
                    beat_idx_d = '0;
                    shift_d    = buf_din;
                end
            end

            SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        beat_idx_d = '0;
                        if (buf_rd) begin
                            shift_d = buf_din;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                        shift_d    = shift_q >> BEAT_WIDTH;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, beat index and packet register, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            state_q    <= IDLE;
            beat_idx_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Completed-packet counter; wraps naturally at the top of its range.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (last_xfer) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

endmodule : outdata_serializer

// File: tb/tb_outdata_serializer.sv
// Directed self-checking bench for outdata_serializer (default 128/32 widths).
// Inputs change 1 ns after the rising edge; outputs are checked before the
// next edge, after the combinational pop strobe has settled.
module tb_outdata_serializer;

    localparam int PW = 128;
    localparam int BW = 32;

    localparam logic [PW-1:0] P1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [PW-1:0] P2 = 128'h00000003_00000007_A5A5A5A5_13579BDF;

    logic          clk = 1'b0;
    logic          rst;
    logic          buf_vld;
    logic [PW-1:0] buf_din;
    logic          buf_rd;
    logic          out_vld;
    logic          out_rdy;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic [15:0]   pkt_cnt;
`ifdef OUTDATA_SER_PARITY_EN
    logic          out_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt;

    outdata_serializer #(.PKT_WIDTH(PW), .BEAT_WIDTH(BW)) dut (
        .clk      (clk),
        .rst      (rst),
        .buf_vld  (buf_vld),
        .buf_din  (buf_din),
        .buf_rd   (buf_rd),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
`ifdef OUTDATA_SER_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [BW-1:0] beat_of(input logic [PW-1:0] p, input int i);
        return p[i*BW +: BW];
    endfunction

    task automatic expect_beat(input string tag, input logic [BW-1:0] d,
                               input logic last, input logic rd);
        check({tag, "_vld"},  out_vld,  1'b1);
        check({tag, "_busy"}, busy,     1'b1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_last"}, out_last, last);
        check({tag, "_rd"},   buf_rd,   rd);
    endtask

    task automatic expect_idle(input string tag, input logic [15:0] cnt);
        check({tag, "_vld"},  out_vld,  1'b0);
        check({tag, "_busy"}, busy,     1'b0);
        check({tag, "_last"}, out_last, 1'b0);
        check({tag, "_cnt"},  pkt_cnt,  cnt);
    endtask

    initial begin
        rst     = 1'b1;
        buf_vld = 1'b0;
        buf_din = '0;
        out_rdy = 1'b1;
        step();
        step();

        // Reset state, and reset beating a simultaneous buf_vld.
        check("rst_data", out_data, 32'h0);
        expect_idle("rst", 16'h0);
        buf_vld = 1'b1;
        buf_din = P1;
        settle();
        check("rst_vs_vld_rd", buf_rd, 1'b0);
        step();
        check("rst_hold_vld", out_vld, 1'b0);
        buf_vld = 1'b0;
        rst     = 1'b0;
        settle();
        exp_cnt = 16'h0;

        // Reset during beat 3 aborts the packet; the next packet pops normally.
        buf_vld = 1'b1;
        buf_din = P1;
        settle();
        check("ab_pop_rd", buf_rd, 1'b1);
        step();
        buf_vld = 1'b0;
        settle();
        expect_beat("ab_b0", 32'h76543210, 1'b0, 1'b0);
        step();
        expect_beat("ab_b1", 32'hFEDCBA98, 1'b0, 1'b0);
        step();
        expect_beat("ab_b2", 32'h89ABCDEF, 1'b0, 1'b0);
        rst     = 1'b1;
        buf_vld = 1'b1;
        buf_din = P2;
        settle();
        check("ab_rst_rd", buf_rd, 1'b0);
        step();
        check("ab_data", out_data, 32'h0);
        expect_idle("ab_after", exp_cnt);
        rst = 1'b0;
        settle();
        check("ab_repop_rd", buf_rd, 1'b1);
        step();
        buf_vld = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("ab_p2_b%0d", i), beat_of(P2, i), (i == 3), 1'b0);
`ifdef OUTDATA_SER_PARITY_EN
            if (i == 2) check("par_7", out_par, 1'b1);
            if (i == 3) check("par_3", out_par, 1'b0);
`endif
            step();
        end
        exp_cnt = exp_cnt + 16'h1;
        expect_idle("ab_done", exp_cnt);

        // Single packet, out_rdy held high: one pop, four beats, one count.
        buf_vld = 1'b1;
        buf_din = P1;
        settle();
        check("sp_pop_rd", buf_rd, 1'b1);
        step();
        buf_vld = 1'b0;
        settle();
        expect_beat("sp_b0", 32'h76543210, 1'b0, 1'b0);
        step();
        expect_beat("sp_b1", 32'hFEDCBA98, 1'b0, 1'b0);
        step();
        expect_beat("sp_b2", 32'h89ABCDEF, 1'b0, 1'b0);
        step();
        expect_beat("sp_b3", 32'h01234567, 1'b1, 1'b0);
        step();
        exp_cnt = exp_cnt + 16'h1;
        expect_idle("sp_done", exp_cnt);

        // Two packets back-to-back: pop on beat 4, eight beats with no gap.
        buf_vld = 1'b1;
        buf_din = P1;
        settle();
        check("bb_pop_rd", buf_rd, 1'b1);
        step();
        buf_din = P2;
        settle();
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("bb_p1_b%0d", i), beat_of(P1, i), (i == 3), (i == 3));
            step();
        end
        buf_vld = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("bb_p2_b%0d", i), beat_of(P2, i), (i == 3), 1'b0);
            step();
        end
        exp_cnt = exp_cnt + 16'h2;
        expect_idle("bb_done", exp_cnt);

        // Stall on beat 2 for three cycles; buf_vld high must not pop.
        buf_vld = 1'b1;
        buf_din = P1;
        settle();
        step();
        buf_vld = 1'b0;
        settle();
        expect_beat("st_b0", 32'h76543210, 1'b0, 1'b0);
        step();
        out_rdy = 1'b0;
        buf_vld = 1'b1;
        buf_din = P2;
        for (int i = 0; i < 3; i++) begin
            settle();
            expect_beat($sformatf("st_hold%0d", i), 32'hFEDCBA98, 1'b0, 1'b0);
            step();
        end
        out_rdy = 1'b1;
        buf_vld = 1'b0;
        settle();
        expect_beat("st_b1", 32'hFEDCBA98, 1'b0, 1'b0);
        step();
        expect_beat("st_b2", 32'h89ABCDEF, 1'b0, 1'b0);
        step();
        expect_beat("st_b3", 32'h01234567, 1'b1, 1'b0);
        step();
        exp_cnt = exp_cnt + 16'h1;
        expect_idle("st_done", exp_cnt);

        // Counter wrap: preload 0xFFFF, one packet brings it to 0x0000.
        force dut.pkt_cnt = 16'hFFFF;
        settle();
        release dut.pkt_cnt;
        step();
        buf_vld = 1'b1;
        buf_din = P2;
        settle();
        step();
        buf_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        expect_idle("wrap", 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_outdata_serializer
